wb_fifo_uart_tx: RTL and testbench
==================================

Name: wb_fifo_uart_tx

Overview:
- Wishbone initiator that drains the 8-bit Wishbone FIFO and serialises each popped byte as 8N1 UART on a single TX line.
- It is the reading end of the FIFO: it issues 1-cycle pop strobes, waits for the FIFO's ack, then shifts the byte out.
- It sits between the Z80-side TX FIFO and the serial port pin.

Parameters:
DW, 8, data word width; the shift register and Wishbone data port are DW bits wide.
CLKS_PER_BIT, 16, i_clk cycles per UART bit; minimum 2.
ACK_TIMEOUT, 4, i_clk cycles to wait for i_wb_ack after a strobe before abandoning the request; minimum 2.

Ports:
i_clk  input  1  system clock; the only clock.
i_reset_n  input  1  asynchronous, active-low reset.
i_enable  input  1  when high, allows a new byte to be fetched.
i_fifo_empty  input  1  FIFO empty flag, sampled combinationally.
o_wb_cyc  output  1  bus cycle; high from the strobe cycle through ack or timeout.
o_wb_stb  output  1  pop request; exactly one cycle long.
o_wb_we  output  1  constant 0; this block only reads.
i_wb_data  input  DW  popped data from the FIFO.
i_wb_ack  input  1  FIFO acknowledge.
i_wb_stall  input  1  FIFO stall; ignored, because it reflects write back-pressure only.
o_tx  output  1  serial line; idle is 1.
o_busy  output  1  high in every state except IDLE.
o_err  output  1  one-cycle pulse when a pop is abandoned by timeout.

Behaviour:
- Reset (asynchronous, immediate):
  - o_tx=1; o_wb_cyc, o_wb_stb, o_wb_we, o_busy and o_err all 0.
  - state=IDLE; all counters cleared.
- States: IDLE, REQ, WAIT_ACK, START, DATA, STOP.
- IDLE: if i_enable && !i_fifo_empty, go to REQ. Otherwise stay, with o_tx=1.
- REQ (1 cycle):
  - o_wb_stb=1, o_wb_cyc=1.
  - Always goes to WAIT_ACK; stb is never held for a second cycle.
- WAIT_ACK:
  - o_wb_cyc=1, o_wb_stb=0. The timeout counter starts at 1 in this state.
  - On i_wb_ack: latch i_wb_data into the shift register in that same cycle, then go to START (o_wb_cyc=0 from the next cycle).
  - If the counter reaches ACK_TIMEOUT without an ack: pulse o_err for 1 cycle, drop o_wb_cyc, go to IDLE. The byte is lost and o_tx is never driven low.
  - Nominal latency: ack arrives in the cycle after the stb.
- START: o_tx=0 for CLKS_PER_BIT cycles.
- DATA:
  - DW bits, LSB first, each bit held for CLKS_PER_BIT cycles.
  - A 3-bit index (clog2(DW) bits in general) wraps from DW-1 into STOP.
- STOP: o_tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - IDLE re-evaluates the request condition in its first cycle.
  - With back-to-back data, the mark time between frames is CLKS_PER_BIT plus 3 cycles (IDLE, REQ, ack cycle).
- Frame length: (DW+2)*CLKS_PER_BIT cycles, measured from the first START cycle.
- Baud counter: counts 0..CLKS_PER_BIT-1 and restarts at each bit boundary. There is no fractional accumulation.
- i_enable falling mid-frame or mid-request: the current request and frame complete; no new fetch starts.
- i_wb_ack outside WAIT_ACK: ignored, with no state or data change.
- i_fifo_empty is only sampled in IDLE.
- o_tx is registered and never glitches during shifting.
- Reset mid-frame: the line returns to 1 asynchronously; any partially sent byte is discarded.

Decomposition:
- Shared package, wb_uart_pkg:
  - state encoding localparams (IDLE=0 .. STOP=5);
  - UART idle and start levels;
  - a clog2 helper for the counter widths.
- One sub-module, uart_baud_gen:
  - parameter CLKS_PER_BIT;
  - inputs i_clk, i_reset_n and a synchronous restart;
  - output o_tick, one cycle per bit period.
  - The top FSM advances bits on o_tick.

Test Plan:
1. Hold i_reset_n=0 for 3 cycles with i_fifo_empty=0 and i_enable=1 -> o_tx=1, o_wb_stb=0, o_wb_cyc=0, o_busy=0 throughout.
2. CLKS_PER_BIT=4; FIFO holds 0xA5; ack the cycle after stb -> exactly one stb cycle, then o_tx = 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles (40 cycles total); then o_busy=0.
3. FIFO holds 0x00 then 0xFF, i_enable=1 -> two stb pulses; second start bit begins exactly 4+3 cycles after the first stop bit begins; second frame's data bits are all 1.
4. FIFO non-empty, responder never acks, ACK_TIMEOUT=4 -> o_err high for exactly 1 cycle, 4 cycles after stb; o_tx stays 1; a new stb follows (retry from IDLE).
5. Assert i_reset_n=0 during DATA bit 3 -> o_tx=1 in the same cycle without waiting for a clock edge; after release the next frame starts clean with a start bit.
6. i_enable=0 with FIFO non-empty -> no stb for 50 cycles; then drop i_enable 2 cycles into a START -> the full frame completes, and no further stb is issued.

Source files
------------

// File: rtl/wb_uart_pkg.sv
// Shared definitions for the Wishbone FIFO drain / UART transmitter:
// state encoding, line levels and a width helper.
package wb_uart_pkg;

  localparam logic [2:0] ST_IDLE_ENC     = 3'd0;
  localparam logic [2:0] ST_REQ_ENC      = 3'd1;
  localparam logic [2:0] ST_WAIT_ACK_ENC = 3'd2;
  localparam logic [2:0] ST_START_ENC    = 3'd3;
  localparam logic [2:0] ST_DATA_ENC     = 3'd4;
  localparam logic [2:0] ST_STOP_ENC     = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE     = ST_IDLE_ENC,
    ST_REQ      = ST_REQ_ENC,
    ST_WAIT_ACK = ST_WAIT_ACK_ENC,
    ST_START    = ST_START_ENC,
    ST_DATA     = ST_DATA_ENC,
    ST_STOP     = ST_STOP_ENC
  } state_t;

  localparam logic UART_IDLE  = 1'b1;
  localparam logic UART_START = 1'b0;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/wb_fifo_uart_tx_baud.sv
// Bit-period timer: o_tick marks the last cycle of each UART bit.
module uart_baud_gen
  import wb_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_restart,
  output logic o_tick
);

  localparam int CW = (clog2(CLKS_PER_BIT) < 1) ? 1 : clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_restart || (r_count == LAST)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_tick = !i_restart && (r_count == LAST);

endmodule

// File: rtl/wb_fifo_uart_tx.sv
// Pops bytes from the Wishbone TX FIFO one at a time and sends each as an
// 8N1 UART frame; a pop that is never acknowledged is dropped with o_err.
module wb_fifo_uart_tx
  import wb_uart_pkg::*;
#(
  parameter int DW           = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int ACK_TIMEOUT  = 4
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_enable,
  input  logic          i_fifo_empty,
  output logic          o_wb_cyc,
  output logic          o_wb_stb,
  output logic          o_wb_we,
  input  logic [DW-1:0] i_wb_data,
  input  logic          i_wb_ack,
  input  logic          i_wb_stall,
  output logic          o_tx,
  output logic          o_busy,
  output logic          o_err
);

  localparam int IDX_W = (clog2(DW) < 1) ? 1 : clog2(DW);
  localparam int TO_W  = clog2(ACK_TIMEOUT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DW - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);

  state_t           r_state;
  logic [DW-1:0]    r_shift;
  logic [IDX_W-1:0] r_bit_idx;
  logic [TO_W-1:0]  r_to_cnt;
  logic             r_tx;
  logic             r_cyc;
  logic             r_stb;
  logic             r_busy;
  logic             r_err;

  logic w_tick;
  logic w_baud_restart;
  logic w_unused_stall;

  // Stall only throttles writers into the FIFO, so the reader has no use for it.
  assign w_unused_stall = i_wb_stall;

  // Baud counter is held at zero until the start bit so every bit is full length.
  assign w_baud_restart = !(r_state inside {ST_START, ST_DATA, ST_STOP});

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_restart (w_baud_restart),
    .o_tick    (w_tick)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_to_cnt  <= '0;
      r_tx      <= UART_IDLE;
      r_cyc     <= 1'b0;
      r_stb     <= 1'b0;
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_stb <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_tx <= UART_IDLE;
          if (i_enable && !i_fifo_empty) begin
            r_state <= ST_REQ;
            r_stb   <= 1'b1;
            r_cyc   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ST_REQ: begin
          r_state  <= ST_WAIT_ACK;
          r_to_cnt <= TO_W'(1);
        end
        ST_WAIT_ACK: begin
          if (i_wb_ack) begin
            r_shift  <= i_wb_data;
            r_cyc    <= 1'b0;
            r_tx     <= UART_START;
            r_to_cnt <= '0;
            r_state  <= ST_START;
          end else if (r_to_cnt == TO_LAST) begin
            // Counter reaches ACK_TIMEOUT on this edge: abandon the pop.
            r_err    <= 1'b1;
            r_cyc    <= 1'b0;
            r_busy   <= 1'b0;
            r_to_cnt <= '0;
            r_state  <= ST_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_tx      <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bit_idx <= '0;
            r_state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_bit_idx == LAST_IDX) begin
              r_tx    <= UART_IDLE;
              r_state <= ST_STOP;
            end else begin
              r_tx      <= r_shift[0];
              r_shift   <= r_shift >> 1;
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_tx    <= UART_IDLE;
          r_cyc   <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_tx     = r_tx;
  assign o_wb_cyc = r_cyc;
  assign o_wb_stb = r_stb;
  assign o_wb_we  = 1'b0;
  assign o_busy   = r_busy;
  assign o_err    = r_err;

endmodule

// File: tb/tb_wb_fifo_uart_tx.sv
// Bench for wb_fifo_uart_tx: FIFO/Wishbone responder model, UART line
// decoder and a byte scoreboard.
module tb_wb_fifo_uart_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;
  localparam int ATO = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable;
  logic          fifo_empty;
  logic          wb_cyc, wb_stb, wb_we;
  logic [DW-1:0] wb_data;
  logic          wb_ack;
  logic          wb_stall;
  logic          tx, busy, err;

  always #5 clk = ~clk;

  wb_fifo_uart_tx #(
    .DW(DW), .CLKS_PER_BIT(CPB), .ACK_TIMEOUT(ATO)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_enable(enable), .i_fifo_empty(fifo_empty),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we), .i_wb_data(wb_data),
    .i_wb_ack(wb_ack), .i_wb_stall(wb_stall), .o_tx(tx), .o_busy(busy), .o_err(err)
  );

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         start_q[$];
  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;
  int stb_count = 0;
  int frames_done = 0;
  logic mon_en, ack_en, ack_pending, take;
  logic [7:0] mon_byte;
  int mon_start, t_stb, base, s;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc_cnt);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    fifo_empty = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (frames_done < target) check_value("frame_timeout", frames_done, target);
  endtask

  task automatic wait_tx_low(input string tag, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (tx !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (tx !== 1'b0) check_value(tag, tx, 0);
  endtask

  task automatic wait_stb(input string tag, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (wb_stb !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_value(tag, wb_stb, 1);
  endtask

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
  always @(negedge clk) if (wb_stb === 1'b1) stb_count <= stb_count + 1;

  // Responder: ack the cycle after a strobe, popping the FIFO model.
  initial begin
    wb_ack = 1'b0;
    wb_data = '0;
    ack_pending = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      wb_ack = 1'b0;
      take = ack_pending && rst_n;
      ack_pending = wb_stb && ack_en && rst_n;
      if (take && fifo_q.size() > 0) begin
        wb_ack = 1'b1;
        wb_data = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
        if (mon_en) exp_q.push_back(wb_data);
        $display("pop  0x%02h at cycle %0d", wb_data, cyc_cnt);
      end
    end
  end

  // Line decoder: one frame per start bit, each level must hold CPB cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && mon_en && tx === 1'b0) begin
        mon_start = cyc_cnt;
        start_q.push_back(cyc_cnt);
        repeat (CPB - 1) begin
          @(negedge clk);
          check_value("start_bit", tx, 0);
        end
        for (int b = 0; b < DW; b++) begin
          for (int k = 0; k < CPB; k++) begin
            @(negedge clk);
            if (k == 0) mon_byte[b] = tx;
            else check_value("bit_hold", tx, mon_byte[b]);
          end
        end
        for (int k = 0; k < CPB; k++) begin
          @(negedge clk);
          check_value("stop_bit", tx, 1);
        end
        check_value("exp_avail", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check_value("frame_data", mon_byte, exp_q.pop_front());
        frames_done++;
        $display("frame %0d start@%0d data 0x%02h", frames_done, mon_start, mon_byte);
      end
    end
  end

  initial begin
    rst_n = 1'b0; enable = 1'b1; fifo_empty = 1'b1; wb_stall = 1'b0;
    mon_en = 1'b1; ack_en = 1'b1;

    // 1: reset held with data waiting
    push_byte(8'hA5);
    repeat (3) begin
      @(negedge clk);
      check_value("rst_tx", tx, 1);
      check_value("rst_stb", wb_stb, 0);
      check_value("rst_cyc", wb_cyc, 0);
      check_value("rst_busy", busy, 0);
      check_value("rst_err", err, 0);
      check_value("rst_we", wb_we, 0);
    end
    rst_n = 1'b1;

    // 2: single 0xA5 frame
    wait_frames(1, 200);
    check_value("t2_stb_count", stb_count, 1);
    @(negedge clk);
    check_value("t2_busy_after", busy, 0);
    check_value("t2_cyc_after", wb_cyc, 0);

    // 3: back-to-back 0x00, 0xFF
    push_byte(8'h00);
    push_byte(8'hFF);
    wait_frames(3, 300);
    check_value("t3_stb_count", stb_count, 3);
    if (start_q.size() >= 3) check_value("t3_gap", start_q[2] - start_q[1], (DW + 1) * CPB + CPB + 3);

    // 4: no ack -> timeout, retry
    ack_en = 1'b0;
    push_byte(8'h3C);
    wait_stb("t4_stb", 50);
    t_stb = cyc_cnt;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (err === 1'b1) break;
      check_value("t4_tx_idle", tx, 1);
    end
    check_value("t4_err_seen", err, 1);
    check_value("t4_err_delay", cyc_cnt - t_stb, ATO);
    check_value("t4_cyc_drop", wb_cyc, 0);
    check_value("t4_tx_err", tx, 1);
    @(negedge clk);
    check_value("t4_err_pulse", err, 0);
    wait_stb("t4_retry", 20);
    ack_en = 1'b1;
    wait_frames(4, 200);

    // 5: asynchronous reset during data bit 3
    mon_en = 1'b0;
    push_byte(8'h00);
    wait_tx_low("t5_start", 50);
    repeat (CPB + 3 * CPB + 1) @(negedge clk);
    check_value("t5_pre_tx", tx, 0);
    #1 rst_n = 1'b0;
    #1;
    check_value("t5_async_tx", tx, 1);
    check_value("t5_async_busy", busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    push_byte(8'h5A);
    wait_frames(5, 200);

    // 6: enable gating
    enable = 1'b0;
    push_byte(8'h81);
    s = stb_count;
    repeat (50) @(negedge clk);
    check_value("t6_no_stb", stb_count, s);
    check_value("t6_idle_busy", busy, 0);
    enable = 1'b1;
    wait_tx_low("t6_start", 50);
    repeat (2) @(negedge clk);
    enable = 1'b0;
    push_byte(8'h11);
    base = stb_count;
    wait_frames(6, 200);
    repeat (50) @(negedge clk);
    check_value("t6_no_restb", stb_count, base);
    check_value("t6_busy_end", busy, 0);
    check_value("t6_fifo_left", fifo_q.size(), 1);
    check_value("t6_exp_left", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
